// File: rtl/vdp_bus_port.sv
// CPU-bus responder for the 16-byte VDP register window, bridging the data port to VRAM.
// Optional macro VDP_IRQ_EN adds the active-low irq_n output.
module vdp_bus_port #(
  parameter logic [15:0] BASE_ADDR   = 16'hFFF0,
  parameter int          VADDR_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            address,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic                   rd,
  input  logic                   wr,
  output logic                   wait_n,
  input  logic                   vblank,
  output logic                   display_en,
  output logic [3:0]             border,
  output logic                   vram_req,
  output logic                   vram_we,
  output logic [VADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]             vram_wdata,
  input  logic                   vram_ack,
  input  logic [7:0]             vram_rdata
`ifdef VDP_IRQ_EN
  ,
  output logic                   irq_n
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                 state_q, state_d;
  logic [VADDR_WIDTH-1:0] ptr_q, ptr_d, vaddr_q, vaddr_d;
  logic [7:0]             latch_q, latch_d, wdata_q, wdata_d;
  logic                   pf_pend_q, pf_pend_d, discard_q, discard_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [3:0]             border_q, border_d;
  logic                   vb_q, flag_q, flag_d;

  logic       hit, busy, stall, acc_wr, acc_rd, vdata_wr, vdata_rd, vaddr_wr, status_rd;
  logic [3:0] offs;

  assign hit       = (address[15:4] == BASE_ADDR[15:4]);
  assign offs      = address[3:0];
  assign busy      = (state_q != S_IDLE) || pf_pend_q;
  assign stall     = hit && (offs == 4'h4) && (rd || wr) && busy;
  assign acc_wr    = hit && wr && !stall;
  assign acc_rd    = hit && rd && !stall;
  assign vdata_wr  = acc_wr && (offs == 4'h4);
  assign vdata_rd  = acc_rd && (offs == 4'h4);
  assign vaddr_wr  = acc_wr && ((offs == 4'h2) || (offs == 4'h3));
  assign status_rd = acc_rd && (offs == 4'h1);

  assign wait_n     = !stall;
  assign display_en = ctrl_q[0];
  assign border     = border_q;
  assign vram_req   = (state_q != S_IDLE);
  assign vram_we    = (state_q == S_WRITE);
  assign vram_addr  = vaddr_q;
  assign vram_wdata = wdata_q;

`ifdef VDP_IRQ_EN
  assign irq_n = !(flag_q && ctrl_q[1]);
`endif

  always_comb begin
    ptr_d    = ptr_q;
    ctrl_d   = ctrl_q;
    border_d = border_q;
    flag_d   = flag_q;
    if (acc_wr) begin
      case (offs)
        4'h0:    ctrl_d   = data_in[1:0];
        4'h2:    ptr_d    = {ptr_q[VADDR_WIDTH-1:8], data_in};
        4'h3:    ptr_d    = {data_in[VADDR_WIDTH-9:0], ptr_q[7:0]};
        4'h4:    ptr_d    = ptr_q + {{(VADDR_WIDTH-1){1'b0}}, 1'b1};
        4'h5:    border_d = data_in[3:0];
        default: ;
      endcase
    end
    if (vdata_rd) ptr_d = ptr_q + {{(VADDR_WIDTH-1){1'b0}}, 1'b1};
    // A vblank rise in the same cycle as a clearing STATUS read keeps the flag set.
    if (status_rd) flag_d = 1'b0;
    if (vblank && !vb_q) flag_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    wdata_d   = wdata_q;
    latch_d   = latch_q;
    pf_pend_d = pf_pend_q;
    discard_d = discard_q;
    case (state_q)
      S_IDLE: begin
        if (vdata_wr) begin
          state_d = S_WRITE;
          vaddr_d = ptr_q;
          wdata_d = data_in;
        end else if (vdata_rd || vaddr_wr || pf_pend_q) begin
          state_d   = S_READ;
          vaddr_d   = ptr_d;
          pf_pend_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (vaddr_wr) pf_pend_d = 1'b1;
        if (vram_ack) state_d = S_IDLE;
      end
      S_READ: begin
        // Pointer moved under an in-flight prefetch: drop its data, refetch afterwards.
        if (vaddr_wr) begin
          pf_pend_d = 1'b1;
          discard_d = 1'b1;
        end
        if (vram_ack) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !vaddr_wr) latch_d = vram_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_out = 8'h00;
    if (hit && rd) begin
      case (offs)
        4'h0:    data_out = {6'b0, ctrl_q};
        4'h1:    data_out = {busy, 6'b0, flag_q};
        4'h2:    data_out = ptr_q[7:0];
        4'h3:    data_out = 8'(ptr_q[VADDR_WIDTH-1:8]);
        4'h4:    data_out = latch_q;
        4'h5:    data_out = {4'b0, border_q};
        default: data_out = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      vaddr_q   <= '0;
      latch_q   <= 8'h00;
      wdata_q   <= 8'h00;
      pf_pend_q <= 1'b0;
      discard_q <= 1'b0;
      ctrl_q    <= 2'b00;
      border_q  <= 4'h0;
      vb_q      <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      vaddr_q   <= vaddr_d;
      latch_q   <= latch_d;
      wdata_q   <= wdata_d;
      pf_pend_q <= pf_pend_d;
      discard_q <= discard_d;
      ctrl_q    <= ctrl_d;
      border_q  <= border_d;
      vb_q      <= vblank;
      flag_q    <= flag_d;
    end
  end

endmodule

// File: tb/tb_vdp_bus_port.sv
// Bench for vdp_bus_port: CPU bus tasks plus a VRAM responder checking a queue of expected accesses.
module tb_vdp_bus_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        rd = 1'b0, wr = 1'b0;
  logic        wait_n;
  logic        vblank = 1'b0;
  logic        display_en;
  logic [3:0]  border;
  logic        vram_req, vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [7:0]  vram_rdata;
`ifdef VDP_IRQ_EN
  logic        irq_n;
`endif

  vdp_bus_port dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in), .data_out(data_out),
    .rd(rd), .wr(wr), .wait_n(wait_n), .vblank(vblank), .display_en(display_en),
    .border(border), .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
`ifdef VDP_IRQ_EN
    , .irq_n(irq_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } vtx_t;

  vtx_t       exp_q[$];
  logic [7:0] mem [0:16383];
  int         ack_delay = 0;
  int         wcnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         stalls;
  logic [7:0] rdat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input logic [13:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic exp_wr(input logic [13:0] a, input logic [7:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  // VRAM arbiter model: acks each request after ack_delay cycles, checking it against the queue.
  initial begin
    vtx_t e;
    vram_ack   = 1'b0;
    vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (vram_ack) begin
        vram_ack = 1'b0;
        wcnt     = 0;
      end else if (!vram_req) begin
        wcnt = 0;
      end else if (wcnt < ack_delay) begin
        wcnt++;
      end else begin
        if (exp_q.size() == 0) begin
          check("vram_spurious_req", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("vram_we", vram_we, e.we);
          check("vram_addr", vram_addr, e.addr);
          if (e.we) check("vram_wdata", vram_wdata, e.data);
        end
        vram_rdata = mem[vram_addr];
        if (vram_we) mem[vram_addr] = vram_wdata;
        vram_ack = 1'b1;
      end
    end
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, output int st);
    st = 0;
    @(negedge clk);
    address = a; data_in = d; wr = 1'b1;
    #1;
    while (!wait_n && st < 200) begin
      @(negedge clk); #1; st++;
    end
    if (st >= 200) check("cpu_wr_timeout", st, 0);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    int st = 0;
    @(negedge clk);
    address = a; rd = 1'b1;
    #1;
    while (!wait_n && st < 200) begin
      @(negedge clk); #1; st++;
    end
    if (st >= 200) check("cpu_rd_timeout", st, 0);
    d = data_out;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || vram_req) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) check("settle_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[14'h3FFF] = 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_display_en", display_en, 0);
    check("rst_border", border, 0);
    check("rst_vram_req", vram_req, 0);
    check("rst_wait_n", wait_n, 1);
    reset = 1'b1;
    cpu_rd(16'hFFF1, rdat); check("rst_status", rdat, 8'h00);

    // Pointer to 0x3FFF; the HI write lands while the LO prefetch is in flight.
    ack_delay = 2;
    exp_rd(14'h00FF); cpu_wr(16'hFFF2, 8'hFF, stalls);
    exp_rd(14'h3FFF); cpu_wr(16'hFFF3, 8'h3F, stalls);
    settle();
    exp_rd(14'h0000); cpu_rd(16'hFFF4, rdat); check("vdata_rd_3fff", rdat, 8'hA5);
    settle();
    exp_rd(14'h0001); cpu_rd(16'hFFF4, rdat); check("vdata_rd_wrap", rdat, mem[0]);
    settle();
    cpu_rd(16'hFFF2, rdat); check("ptr_lo", rdat, 8'h01);
    cpu_rd(16'hFFF3, rdat); check("ptr_hi", rdat, 8'h00);
    exp_rd(14'h3F01); cpu_wr(16'hFFF3, 8'hFF, stalls); settle();
    cpu_rd(16'hFFF3, rdat); check("ptr_hi_mask", rdat, 8'h3F);
    exp_rd(14'h3F20); cpu_wr(16'hFFF2, 8'h20, stalls); settle();
    exp_rd(14'h0120); cpu_wr(16'hFFF3, 8'h01, stalls); settle();

    // Back-to-back VDATA writes with a slow arbiter.
    ack_delay = 3;
    exp_wr(14'h0120, 8'h12); cpu_wr(16'hFFF4, 8'h12, stalls);
    check("vdata_wr1_nostall", stalls, 0);
    exp_wr(14'h0121, 8'h34); cpu_wr(16'hFFF4, 8'h34, stalls);
    check("vdata_wr2_stalled", (stalls > 0), 1);
    settle();
    exp_wr(14'h0122, 8'h77); cpu_wr(16'hFFF4, 8'h77, stalls);
    cpu_rd(16'hFFF1, rdat); check("status_busy", rdat, 8'h80);
    settle();
    cpu_rd(16'hFFF1, rdat); check("status_idle", rdat, 8'h00);
    cpu_rd(16'hFFF2, rdat); check("ptr_after_wr", rdat, 8'h23);
    exp_rd(14'h0120); cpu_wr(16'hFFF2, 8'h20, stalls); settle();
    exp_rd(14'h0121); cpu_rd(16'hFFF4, rdat); check("readback_0", rdat, 8'h12);
    exp_rd(14'h0122); cpu_rd(16'hFFF4, rdat); check("readback_1", rdat, 8'h34);
    exp_rd(14'h0123); cpu_rd(16'hFFF4, rdat); check("readback_2", rdat, 8'h77);
    settle();

    // vblank flag set / clear / collision.
    @(negedge clk); vblank = 1'b1;
    repeat (2) @(negedge clk);
    cpu_rd(16'hFFF1, rdat); check("vblank_set", rdat, 8'h01);
    cpu_rd(16'hFFF1, rdat); check("vblank_clr", rdat, 8'h00);
    @(negedge clk); vblank = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    vblank = 1'b1; address = 16'hFFF1; rd = 1'b1;
    #1; check("vblank_coll_rd", data_out, 8'h00);
    @(posedge clk); #1; rd = 1'b0;
    cpu_rd(16'hFFF1, rdat); check("vblank_set_wins", rdat, 8'h01);
    cpu_rd(16'hFFF1, rdat); check("vblank_clr2", rdat, 8'h00);
    @(negedge clk); vblank = 1'b0;

    // Register writes, reserved offsets, out-of-window addresses.
    cpu_wr(16'hFFF5, 8'hF7, stalls); check("border", border, 4'h7);
    cpu_wr(16'hFFF0, 8'hFF, stalls); check("display_en", display_en, 1);
    cpu_rd(16'hFFF0, rdat); check("ctrl_rd", rdat, 8'h03);
    cpu_wr(16'hFFF9, 8'hAA, stalls);
    cpu_rd(16'hFFF9, rdat); check("rsvd_rd", rdat, 8'h00);
    check("rsvd_border", border, 4'h7);
    cpu_rd(16'hFFF0, rdat); check("rsvd_ctrl", rdat, 8'h03);
    cpu_wr(16'hFFE0, 8'h00, stalls); check("miss_ctrl", display_en, 1);
    cpu_wr(16'hFFE5, 8'h00, stalls); check("miss_border", border, 4'h7);
    cpu_rd(16'hFFEF, rdat); check("miss_rd", rdat, 8'h00);
    cpu_rd(16'hFFE4, rdat); check("miss_rd_vdata", rdat, 8'h00);
    settle();

`ifdef VDP_IRQ_EN
    cpu_wr(16'hFFF0, 8'h02, stalls); check("irq_idle", irq_n, 1);
    @(negedge clk); vblank = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_assert", irq_n, 0);
    cpu_rd(16'hFFF1, rdat); check("irq_release", irq_n, 1);
    @(negedge clk); vblank = 1'b0;
`endif

    // Reset in the middle of a VRAM write: request drops and is not replayed.
    ack_delay = 1000;
    cpu_wr(16'hFFF4, 8'h99, stalls);
    repeat (2) @(negedge clk);
    check("midrst_req_before", vram_req, 1);
    check("midrst_we_before", vram_we, 1);
    reset = 1'b0;
    #1; check("midrst_req_drop", vram_req, 0);
    check("midrst_wait_n", wait_n, 1);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_replay", vram_req, 0);
    cpu_rd(16'hFFF2, rdat); check("midrst_ptr", rdat, 8'h00);
    cpu_rd(16'hFFF0, rdat); check("midrst_ctrl", rdat, 8'h00);
    check("midrst_border", border, 4'h0);
    cpu_rd(16'hFFF4, rdat); check("midrst_latch", rdat, 8'h00);
    exp_q.delete();
    ack_delay = 0;
    exp_rd(14'h0001);
    settle();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/vdp_bus_port.md
Name: vdp_bus_port

Overview:
- CPU-bus responder for the VDP register window at BASE_ADDR..BASE_ADDR+15 (FFF0-FFFF).
- Decodes CPU reads and writes and holds the VDP control registers.
- Bridges the CPU data port to VRAM through an auto-incrementing pointer and a req/ack handshake toward the VDP's VRAM arbiter.
- Sits between the system bus and the Vdp instance in the top level.

Parameters:
- BASE_ADDR, 16'hFFF0, base of the 16-byte register window; low 4 bits must be 0.
- VADDR_WIDTH, 14, VRAM pointer width in bits (max 16).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  16  CPU bus address.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; valid the same cycle rd is high and the window is hit, else 0.
- rd  in  1  CPU read strobe, one cycle per access.
- wr  in  1  CPU write strobe, one cycle per access.
- wait_n  out  1  low stalls the CPU; CPU holds address/data/strobe while low.
- vblank  in  1  level from the sync generator.
- display_en  out  1  CTRL bit0.
- border  out  4  border colour register.
- vram_req  out  1  VRAM request; held until vram_ack.
- vram_we  out  1  1 = write, 0 = read; stable while vram_req.
- vram_addr  out  VADDR_WIDTH  VRAM address; stable while vram_req.
- vram_wdata  out  8  VRAM write data; stable while vram_req.
- vram_ack  in  1  one-cycle completion; read data valid on vram_rdata that cycle.
- vram_rdata  in  8  VRAM read data.

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0 CTRL: R/W; bit0 display_en, bit1 irq_en; other bits read 0.
  - 1 STATUS: R; bit0 vblank_flag, bit7 busy. A read clears vblank_flag on the following edge.
  - 2 VADDR_LO: R/W.
  - 3 VADDR_HI: R/W; bits above VADDR_WIDTH-8 read 0. A write to either VADDR byte starts a prefetch read.
  - 4 VDATA: see VDATA rules below.
  - 5 BORDER: bits 3:0.
  - 6-F: reserved; reads return 0, writes are ignored.
- VDATA access:
  - Write: loads the write buffer, then pointer += 1.
  - Read: returns the prefetch latch, then pointer += 1 and a prefetch read of the new pointer starts.
- Pointer wraps modulo 2^VADDR_WIDTH; 0x3FFF + 1 = 0x0000.
- vblank_flag is set on the rising edge of vblank (vblank registered once; flag set the cycle after the 0->1 transition is seen). If a set and a clearing STATUS read occur in the same cycle, the set wins.
- VRAM state machine:
  - IDLE: a pending write (priority) -> WRITE; else a pending prefetch -> READ.
  - WRITE: vram_req=1, vram_we=1; on vram_ack -> IDLE.
  - READ: vram_req=1, vram_we=0; on vram_ack latch vram_rdata into the prefetch latch -> IDLE.
  - vram_req rises the cycle after entry to WRITE/READ. Minimum latency from CPU write strobe to vram_req is 1 cycle.
- busy = state != IDLE or any request pending.
- wait_n = 0 when a VDATA access arrives while busy; the access completes on the cycle busy falls. Accesses to non-VDATA offsets never stall.
- A write to VADDR while a READ is in flight: the in-flight result is discarded and a new prefetch is issued after its ack.
- Reset values: CTRL=0, BORDER=0, pointer=0, prefetch latch=0, vblank_flag=0, state IDLE, vram_req=0, wait_n=1, data_out=0.
- Reset asserted mid-transaction: vram_req drops immediately; the lost write is not replayed.

Optional Feature:
- Macro VDP_IRQ_EN.
- Defined: adds output irq_n (1 bit, active-low) = !(vblank_flag & irq_en). It releases when STATUS is read. Reset value 1.
- Undefined: no irq_n port; CTRL bit1 still stores and reads back but has no effect.

Test Plan:
- Reset: deassert reset -> display_en=0, border=0, vram_req=0, wait_n=1; read FFF1 -> 0x00.
- Write FFF2=0xFF, FFF3=0x3F -> prefetch vram_req with vram_we=0, vram_addr=0x3FFF. Ack with rdata 0xA5 -> read FFF4 returns 0xA5 and the next prefetch addr is 0x0000 (wrap).
- Write FFF4=0x12 then immediately FFF4=0x34, ack held off 3 cycles -> wait_n low until the first ack. VRAM writes are 0x12@N then 0x34@N+1.
- vblank 0->1 -> STATUS bit0=1; STATUS read -> next read bit0=0. Set and read in the same cycle -> bit0 stays 1.
- Write FFF5=0xF7 -> border=0x7; write/read FFF9 -> data_out 0, no register changes; address 0xFFEF -> no response.
- With VDP_IRQ_EN: CTRL=0x02, vblank rise -> irq_n=0; STATUS read -> irq_n=1 the next cycle.
